// File: rtl/demux_1_to_8.sv
// Registered 1-to-8 demultiplexer.
// Steers d to the output chosen by sel and drives every other output to zero.
// Outputs, the one-hot destination copy and valid update together, one clock after sampling.
module demux_1_to_8 #(
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    input  logic [2:0]        sel,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] y2,
    output logic [DATA_W-1:0] y3,
    output logic [DATA_W-1:0] y4,
    output logic [DATA_W-1:0] y5,
    output logic [DATA_W-1:0] y6,
    output logic [DATA_W-1:0] y7,
    output logic [7:0]        sel_onehot,
    output logic              valid
);

    logic [DATA_W-1:0] y_d [8];
    logic [DATA_W-1:0] y_q [8];
    logic [7:0]        onehot_d, onehot_q;
    logic              valid_d, valid_q;

    // Next-state: route d to the selected slot only while enabled; idle clears everything.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            y_d[i] = '0;
        end
        onehot_d = 8'h00;
        valid_d  = 1'b0;
        if (en) begin
            y_d[sel] = d;
            onehot_d = 8'h01 << sel;
            valid_d  = 1'b1;
        end
    end

    // State register with synchronous reset that overrides en, d and sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                y_q[i] <= '0;
            end
            onehot_q <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                y_q[i] <= y_d[i];
            end
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
        end
    end

    assign y0         = y_q[0];
    assign y1         = y_q[1];
    assign y2         = y_q[2];
    assign y3         = y_q[3];
    assign y4         = y_q[4];
    assign y5         = y_q[5];
    assign y6         = y_q[6];
    assign y7         = y_q[7];
    assign sel_onehot = onehot_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_demux_1_to_8.sv
// Directed self-checking bench for demux_1_to_8 with an 8-bit data path.
module tb_demux_1_to_8;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] d;
    logic [2:0]   sel;
    logic [W-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic [7:0]   sel_onehot;
    logic         valid;

    int checks;
    int failures;

    // Observed outputs packed as {valid, sel_onehot, y7..y0}.
    logic [72:0] obs;
    assign obs = {valid, sel_onehot, y7, y6, y5, y4, y3, y2, y1, y0};

    demux_1_to_8 #(
        .DATA_W(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .d         (d),
        .sel       (sel),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .y4        (y4),
        .y5        (y5),
        .y6        (y6),
        .y7        (y7),
        .sel_onehot(sel_onehot),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [72:0] exp;
        rst = 1'b1; en = 1'b1; d = 8'h01; sel = 3'd3;
        exp = '0;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset[%0d] got=%h want=%h", c, obs, exp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        logic [72:0] exp;
        logic [63:0] ys;
        logic [7:0]  oh;
        en = 1'b1; d = 8'h01;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            step();
            ys  = 64'd1 << (8 * i);
            oh  = 8'h01 << i;
            exp = {1'b1, oh, ys};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL sweep sel=%0d got=%h want=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_zero_data();
        logic [72:0] exp;
        en = 1'b1; d = 8'h00; sel = 3'd5;
        step();
        exp = {1'b1, 8'h20, 64'h0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL zero_data got=%h want=%h", obs, exp);
        end
        en = 1'b0; d = 8'hFF;
        step();
        exp = '0;
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL idle got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [72:0] exp;
        en = 1'b1; d = 8'h01; sel = 3'd2;
        step();
        exp = {1'b1, 8'h04, 64'h0000_0000_0001_0000};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL b2b_sel2 got=%h want=%h", obs, exp);
        end
        sel = 3'd6;
        step();
        exp = {1'b1, 8'h40, 64'h0001_0000_0000_0000};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL b2b_sel6 got=%h want=%h", obs, exp);
        end
        // Idle afterwards: the previous routed value must not be held.
        en = 1'b0;
        step();
        exp = '0;
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL b2b_clear got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_midstream_reset();
        logic [72:0] exp;
        en = 1'b1; d = 8'h01; sel = 3'd7;
        step();
        exp = {1'b1, 8'h80, 64'h0100_0000_0000_0000};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mid_route got=%h want=%h", obs, exp);
        end
        rst = 1'b1;
        step();
        exp = '0;
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mid_reset got=%h want=%h", obs, exp);
        end
        rst = 1'b0;
        step();
        exp = {1'b1, 8'h80, 64'h0100_0000_0000_0000};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mid_resume got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_wide_data();
        logic [72:0] exp;
        en = 1'b1; d = 8'hA5; sel = 3'd4;
        step();
        exp = {1'b1, 8'h10, 64'h0000_00A5_0000_0000};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL wide_sel4 got=%h want=%h", obs, exp);
        end
        // All-ones data on y0 checks that no bit is dropped at the low end.
        d = 8'hFF; sel = 3'd0;
        step();
        exp = {1'b1, 8'h01, 64'h0000_0000_0000_00FF};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL wide_sel0 got=%h want=%h", obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; en = 1'b0; d = '0; sel = '0;
        test_reset();
        test_sweep();
        test_zero_data();
        test_back_to_back();
        test_midstream_reset();
        test_wide_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1_to_8.md
Name: demux_1_to_8

Overview:
Registered 1-to-8 demultiplexer. Routes a data input to one of eight outputs chosen by a 3-bit select; all other outputs are driven to zero. Used as a generic fan-out/steering stage in datapaths and lab designs. Outputs are registered, one clock after the inputs are sampled.

Parameters:
DATA_W, 1, width in bits of d and of each output y0..y7 (must be >= 1).

Ports:
clk  input  1  rising-edge clock; the block's only clock.
rst  input  1  synchronous, active-high reset, sampled on rising clk.
en  input  1  routing enable; when low, no data is routed.
d  input  DATA_W  data to be steered.
sel  input  3  destination select; 0 selects y0, 7 selects y7.
y0  output  DATA_W  destination 0 (registered).
y1  output  DATA_W  destination 1 (registered).
y2  output  DATA_W  destination 2 (registered).
y3  output  DATA_W  destination 3 (registered).
y4  output  DATA_W  destination 4 (registered).
y5  output  DATA_W  destination 5 (registered).
y6  output  DATA_W  destination 6 (registered).
y7  output  DATA_W  destination 7 (registered).
sel_onehot  output  8  registered one-hot copy of the active destination; bit i corresponds to yi.
valid  output  1  registered; high when the outputs reflect a routed sample.

Behaviour:
- All state updates on the rising edge of clk. No combinational path from inputs to outputs.
- Reset (rst=1 at an edge): y0..y7 = 0, sel_onehot = 8'h00, valid = 0. Reset has priority over en, d and sel.
- Routing (rst=0, en=1 at an edge): y[sel] <= d, all other yi <= 0, sel_onehot <= 1 << sel, valid <= 1.
- Idle (rst=0, en=0 at an edge): y0..y7 <= 0, sel_onehot <= 0, valid <= 0. Outputs do not hold the previous routed value.
- Latency: exactly 1 cycle from the sampling edge to the outputs. Throughput: one sample per cycle. sel and d may change every cycle.
- With d = 0 and en = 1, every yi is 0, but sel_onehot and valid still indicate the selected destination.
- Invariants after any edge: at most one yi is nonzero; sel_onehot is either zero or has exactly one bit set; valid = |sel_onehot.
- All DATA_W bits of d are copied unchanged. No truncation or extension occurs.
- Reset asserted mid-stream: outputs are zero on the following edge. The first routed sample appears one cycle after the first edge with rst=0 and en=1.
- Out-of-range select cannot occur because sel is 3 bits. All 8 codes are legal.
- Before the first reset, output values are undefined. The bench must apply reset first.

Test Plan:
- Reset: hold rst=1 for 2 cycles with en=1, d=1, sel=3 -> y0..y7=0, sel_onehot=00, valid=0 after each edge.
- Sweep: en=1, d=1, sel=0..7 on consecutive cycles -> one cycle later only y[sel]=1, sel_onehot=01,02,04,...,80 in sequence, valid=1.
- Zero data and enable: en=1, d=0, sel=5 -> all yi=0, sel_onehot=20, valid=1. Then en=0 -> sel_onehot=00, valid=0, all yi=0.
- Back-to-back: sel=2 then sel=6 with d=1 on adjacent cycles -> y2=1 for exactly one cycle, followed by y6=1 with y2=0.
- Mid-stream reset: route sel=7, d=1, then assert rst for 1 cycle with en held high -> y7 and valid clear at the reset edge and resume on the next edge.
- Wide data (DATA_W=8): en=1, d=8'hA5, sel=4 -> y4=A5, others 00, sel_onehot=10.
